// File: rtl/psg_pkg.sv
// Shared constants, helpers and FSM encoding for the PSG stereo mixer.
package psg_pkg;

  localparam int CHANNEL_OUTPUT_BITS = 8;
  localparam int MASTER_OUTPUT_BITS  = 7;

  // Accumulator wide enough to hold the sum of all channels at full volume.
  function automatic int acc_bits(input int n_ch, input int ch_bits);
    return ch_bits + $clog2(n_ch);
  endfunction

  typedef enum logic {
    SCAN = 1'b0,
    DONE = 1'b1
  } mix_state_t;

endpackage

// File: rtl/psg_saturate.sv
// Clamps a channel-sum accumulator to the master sample width.
module psg_saturate #(
  parameter int ACC_BITS            = 10,
  parameter int CHANNEL_OUTPUT_BITS = 8,
  parameter int MASTER_OUTPUT_BITS  = 7
) (
  input  logic [ACC_BITS-1:0]           acc,
  output logic [MASTER_OUTPUT_BITS-1:0] sample
);

  localparam int HEAD_BITS = ACC_BITS - CHANNEL_OUTPUT_BITS;

  // Bits below the master window are truncated on purpose.
  logic unused_acc_bits;
  assign unused_acc_bits = &{1'b0, acc};

  assign sample = (acc[ACC_BITS-1 -: HEAD_BITS] == '0)
                ? acc[CHANNEL_OUTPUT_BITS-1 -: MASTER_OUTPUT_BITS]
                : '1;

endmodule

// File: rtl/psg_stereo_mixer.sv
// Time-multiplexed stereo mixer: one channel per clock into saturating
// left/right accumulators, with a per-channel pan register.
module psg_stereo_mixer #(
  parameter int NUM_CHANNELS        = 4,
  parameter int CHANNEL_OUTPUT_BITS = psg_pkg::CHANNEL_OUTPUT_BITS,
  parameter int MASTER_OUTPUT_BITS  = psg_pkg::MASTER_OUTPUT_BITS
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CHANNELS*CHANNEL_OUTPUT_BITS-1:0] volumes,
  input  logic                                        pan_wr,
  input  logic [2*NUM_CHANNELS-1:0]                   pan_data,
  output logic [MASTER_OUTPUT_BITS-1:0]               out_left,
  output logic [MASTER_OUTPUT_BITS-1:0]               out_right,
  output logic                                        sample_valid
);

  import psg_pkg::*;

  localparam int ACC_BITS = acc_bits(NUM_CHANNELS, CHANNEL_OUTPUT_BITS);
  localparam int IDX_BITS = $clog2(NUM_CHANNELS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CHANNELS - 1);

  mix_state_t                    state, state_next;
  logic [IDX_BITS-1:0]           idx, idx_next;
  logic [ACC_BITS-1:0]           acc_l, acc_l_next;
  logic [ACC_BITS-1:0]           acc_r, acc_r_next;
  logic [2*NUM_CHANNELS-1:0]     pan_reg;
  logic [2*NUM_CHANNELS-1:0]     pan_active, pan_active_next;
  logic                          load_sample;
  logic [MASTER_OUTPUT_BITS-1:0] sat_l, sat_r;

  logic [CHANNEL_OUTPUT_BITS-1:0] vol_arr [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]        pan_right_en, pan_left_en;
  logic [ACC_BITS-1:0]            vol_ext;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_unpack
    assign vol_arr[i] = volumes[i*CHANNEL_OUTPUT_BITS +: CHANNEL_OUTPUT_BITS];
  end

  assign pan_right_en = pan_active[NUM_CHANNELS-1:0];
  assign pan_left_en  = pan_active[2*NUM_CHANNELS-1:NUM_CHANNELS];
  assign vol_ext      = {{(ACC_BITS-CHANNEL_OUTPUT_BITS){1'b0}}, vol_arr[idx]};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    acc_l_next      = acc_l;
    acc_r_next      = acc_r;
    pan_active_next = pan_active;
    load_sample     = 1'b0;
    case (state)
      SCAN: begin
        if (pan_left_en[idx])  acc_l_next = acc_l + vol_ext;
        if (pan_right_en[idx]) acc_r_next = acc_r + vol_ext;
        idx_next = idx + IDX_BITS'(1);
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        load_sample = 1'b1;
        acc_l_next  = '0;
        acc_r_next  = '0;
        idx_next    = '0;
        // Pan only changes between scans; a write landing now goes straight through.
        pan_active_next = pan_wr ? pan_data : pan_reg;
        state_next      = SCAN;
      end
      default: state_next = SCAN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SCAN;
      idx          <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      pan_reg      <= '1;
      pan_active   <= '1;
      out_left     <= '0;
      out_right    <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      acc_l        <= acc_l_next;
      acc_r        <= acc_r_next;
      pan_active   <= pan_active_next;
      sample_valid <= load_sample;
      if (pan_wr) pan_reg <= pan_data;
      if (load_sample) begin
        out_left  <= sat_l;
        out_right <= sat_r;
      end
    end
  end

  psg_saturate #(
    .ACC_BITS            (ACC_BITS),
    .CHANNEL_OUTPUT_BITS (CHANNEL_OUTPUT_BITS),
    .MASTER_OUTPUT_BITS  (MASTER_OUTPUT_BITS)
  ) u_sat_left (
    .acc    (acc_l),
    .sample (sat_l)
  );

  psg_saturate #(
    .ACC_BITS            (ACC_BITS),
    .CHANNEL_OUTPUT_BITS (CHANNEL_OUTPUT_BITS),
    .MASTER_OUTPUT_BITS  (MASTER_OUTPUT_BITS)
  ) u_sat_right (
    .acc    (acc_r),
    .sample (sat_r)
  );

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Directed scoreboard bench for psg_stereo_mixer with default parameters.
module tb_psg_stereo_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] volumes;
  logic        pan_wr;
  logic [7:0]  pan_data;
  logic [6:0]  out_left, out_right;
  logic        sample_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Expected samples: {left, right}
  logic [13:0] sb [$];

  always #5 clk = ~clk;

  psg_stereo_mixer dut (
    .clk          (clk),
    .reset        (reset),
    .volumes      (volumes),
    .pan_wr       (pan_wr),
    .pan_data     (pan_data),
    .out_left     (out_left),
    .out_right    (out_right),
    .sample_valid (sample_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next sample_valid at a falling edge, then pops
  // and compares the expected sample. exp_lat > 0 also checks the cycle count.
  task automatic wait_sample(input string tag, input int exp_lat);
    int n = 0;
    logic [13:0] e;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 20);
    check({tag, "_valid"}, 32'(sample_valid), 32'd1);
    if (exp_lat > 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sample_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_left"},  32'(out_left),  32'(e[13:7]));
      check({tag, "_right"}, 32'(out_right), 32'(e[6:0]));
    end
  endtask

  initial begin
    reset    = 1'b1;
    volumes  = {4{8'h20}};
    pan_wr   = 1'b0;
    pan_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_left",  32'(out_left),     32'h0);
    check("rst_right", 32'(out_right),    32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);

    // Default pan, 4 x 0x20 -> 0x80 -> 0x40 on both sides.
    reset = 1'b0;
    sb.push_back({7'h40, 7'h40});
    wait_sample("first", 5);
    sb.push_back({7'h40, 7'h40});
    wait_sample("second", 5);
    @(negedge clk);
    check("pulse_low",  32'(sample_valid), 32'h0);
    check("hold_left",  32'(out_left),     32'h40);
    check("hold_right", 32'(out_right),    32'h40);
    sb.push_back({7'h40, 7'h40});
    wait_sample("third", 4);

    // 4 x 0x40 = 0x100 overflows the master window.
    volumes = {4{8'h40}};
    sb.push_back({7'h7F, 7'h7F});
    wait_sample("sat", 5);

    // Right-only pan written mid-scan: current sample still uses all-ones.
    volumes  = {4{8'h20}};
    pan_wr   = 1'b1;
    pan_data = 8'h0F;
    @(negedge clk);
    pan_wr = 1'b0;
    sb.push_back({7'h40, 7'h40});
    wait_sample("pan0f_before", 4);
    sb.push_back({7'h00, 7'h40});
    wait_sample("pan0f_after", 5);

    // ch0 only at 0xFF; pan 0x21 routes ch0 right and ch1 left.
    volumes  = {8'h00, 8'h00, 8'h00, 8'hFF};
    pan_wr   = 1'b1;
    pan_data = 8'h21;
    @(negedge clk);
    pan_wr = 1'b0;
    sb.push_back({7'h00, 7'h7F});
    wait_sample("pan21_before", 4);
    sb.push_back({7'h00, 7'h7F});
    wait_sample("pan21_after", 5);

    // Under pan 0x21 with 0x20 volumes, then write 0xF0 in the DONE cycle.
    volumes = {4{8'h20}};
    sb.push_back({7'h10, 7'h10});
    sb.push_back({7'h40, 7'h00});
    repeat (4) @(negedge clk);
    pan_wr   = 1'b1;
    pan_data = 8'hF0;
    wait_sample("done_wr_cur", 1);
    pan_wr = 1'b0;
    wait_sample("done_wr_next", 5);

    // Same kind of write mid-scan (idx 2): only the following sample changes.
    sb.push_back({7'h40, 7'h00});
    repeat (2) @(negedge clk);
    pan_wr   = 1'b1;
    pan_data = 8'h0F;
    @(negedge clk);
    pan_wr = 1'b0;
    wait_sample("mid_wr_cur", 2);
    sb.push_back({7'h00, 7'h40});
    wait_sample("mid_wr_next", 5);

    // Reset at idx 2 for one cycle; pan reverts to all ones.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_left",  32'(out_left),     32'h0);
    check("midrst_right", 32'(out_right),    32'h0);
    check("midrst_valid", 32'(sample_valid), 32'h0);
    sb.push_back({7'h40, 7'h40});
    wait_sample("post_rst", 5);
    sb.push_back({7'h40, 7'h40});
    wait_sample("post_rst_pan", 5);

    // ch3 is 0xFF during idx 0..2 but 0x00 in its own slot: sum 0x60.
    volumes = {8'hFF, 8'h20, 8'h20, 8'h20};
    repeat (3) @(negedge clk);
    volumes = {8'h00, 8'h20, 8'h20, 8'h20};
    sb.push_back({7'h30, 7'h30});
    wait_sample("live_ch3", 2);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
